// File: rtl/bitserial_mac.sv
// Bit-serial multiply-accumulate: parallel multiplicand, LSB-first serial multiplier.
// Define BITSERIAL_MAC_SIGNED_EN for two's-complement operands and signed overflow.
module bitserial_mac #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear_acc,
    input  logic [A_WIDTH-1:0]         multiplicand,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic [ACC_WIDTH-1:0]       acc,
    output logic                       overflow
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int IDX_W   = $clog2(B_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACCUM} state_t;

    state_t               state_q, state_d;
    logic [P_WIDTH-1:0]   mcand_q, mcand_d;
    logic [P_WIDTH-1:0]   partial_q, partial_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 clear_q, clear_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [P_WIDTH-1:0]   product_q, product_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 overflow_q, overflow_d;

    logic [P_WIDTH-1:0]   mcand_ext;
    logic [P_WIDTH-1:0]   term;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_flag;
    logic                 sub_term;

`ifdef BITSERIAL_MAC_SIGNED_EN
    assign mcand_ext = P_WIDTH'($signed(multiplicand));
    assign prod_ext  = ACC_WIDTH'($signed(partial_q));
    assign sub_term  = (idx_q == IDX_LAST);
`else
    assign mcand_ext = P_WIDTH'(multiplicand);
    assign prod_ext  = ACC_WIDTH'(partial_q);
    assign sub_term  = 1'b0;
`endif

    assign term     = mcand_q << idx_q;
    assign acc_base = clear_q ? '0 : acc_q;
    assign sum      = {1'b0, acc_base} + {1'b0, prod_ext};

`ifdef BITSERIAL_MAC_SIGNED_EN
    // carry into the MSB xor carry out of it
    assign ovf_flag = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1] ^ acc_base[ACC_WIDTH-1] ^ prod_ext[ACC_WIDTH-1];
`else
    assign ovf_flag = sum[ACC_WIDTH];
`endif

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        partial_d  = partial_q;
        idx_d      = idx_q;
        clear_d    = clear_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        product_d  = product_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d   = mcand_ext;
                    partial_d = bit_in ? mcand_ext : '0;
                    idx_d     = IDX_W'(1);
                    clear_d   = clear_acc;
                    if (clear_acc) overflow_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (bit_in) partial_d = sub_term ? partial_q - term : partial_q + term;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = ACCUM;
                end
            end
            ACCUM: begin
                product_d  = partial_q;
                acc_d      = sum[ACC_WIDTH-1:0];
                overflow_d = overflow_q | ovf_flag;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            partial_q  <= '0;
            idx_q      <= '0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            partial_q  <= partial_d;
            idx_q      <= idx_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            product_q  <= product_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign acc      = acc_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bitserial_mac.sv
// Testbench for bitserial_mac: two instances (24- and 16-bit accumulators) share stimulus
// and are compared against an arithmetic reference model.
module tb_bitserial_mac;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = AW + BW;

    logic          clk = 1'b0;
    logic          rst, start, clear_acc, bit_in, bit_valid;
    logic [AW-1:0] multiplicand;
    logic          busy, done, overflow;
    logic [PW-1:0] product;
    logic [23:0]   acc;
    logic          busy16, done16, overflow16;
    logic [PW-1:0] product16;
    logic [15:0]   acc16;

    int     n_checks = 0;
    int     n_errors = 0;
    longint m_prod, m_acc24, m_acc16;
    bit     m_ovf24, m_ovf16;

    always #5 clk = ~clk;

    bitserial_mac #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(24)) u_dut (
        .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc),
        .multiplicand(multiplicand), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .done(done), .product(product), .acc(acc), .overflow(overflow)
    );

    bitserial_mac #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc),
        .multiplicand(multiplicand), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy16), .done(done16), .product(product16), .acc(acc16), .overflow(overflow16)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sval(input longint v, input int w);
        return ((v >> (w - 1)) & 1) != 0 ? v - (longint'(1) << w) : v;
    endfunction

    function automatic longint model_product(input longint a, input longint b);
`ifdef BITSERIAL_MAC_SIGNED_EN
        return (sval(a, AW) * sval(b, BW)) & ((longint'(1) << PW) - 1);
`else
        return a * b;
`endif
    endfunction

    task automatic model_acc(input longint p, input bit clr, input int w,
                             inout longint a, inout bit ov);
        longint base;
        longint s;
        base = clr ? 0 : a;
        if (clr) ov = 1'b0;
`ifdef BITSERIAL_MAC_SIGNED_EN
        s = sval(base, w) + sval(p, PW);
        if (s > (longint'(1) << (w - 1)) - 1 || s < -(longint'(1) << (w - 1))) ov = 1'b1;
`else
        s = base + p;
        if (s >= (longint'(1) << w)) ov = 1'b1;
`endif
        a = s & ((longint'(1) << w) - 1);
    endtask

    // Caller is positioned at a negedge in IDLE; returns at the negedge where done is seen.
    task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input bit clr,
                          input int stall_pct, input bit junk);
        int edges;
        int stalls;
        int idx;
        bit got;
        m_prod = model_product(longint'(a), longint'(b));
        model_acc(m_prod, clr, 24, m_acc24, m_ovf24);
        model_acc(m_prod, clr, 16, m_acc16, m_ovf16);
        start        = 1'b1;
        multiplicand = a;
        bit_in       = b[0];
        clear_acc    = clr;
        bit_valid    = 1'($urandom_range(0, 1));
        @(posedge clk);
        edges = 0; stalls = 0; idx = 1; got = 1'b0;
        while (!got && edges < 64) begin
            @(negedge clk);
            if (edges == 0) check_val("busy_after_start", busy, 1'b1);
            if (done) got = 1'b1;
            else begin
                start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
                if (junk) begin
                    multiplicand = AW'($urandom);
                    clear_acc    = 1'($urandom_range(0, 1));
                end
                if (idx < BW) begin
                    if (int'($urandom_range(0, 99)) < stall_pct) begin
                        bit_valid = 1'b0;
                        bit_in    = 1'($urandom_range(0, 1));
                        stalls++;
                    end else begin
                        bit_valid = 1'b1;
                        bit_in    = b[idx];
                        idx++;
                    end
                end else begin
                    bit_valid = 1'($urandom_range(0, 1));
                    bit_in    = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                edges++;
            end
        end
        start = 1'b0; clear_acc = 1'b0; bit_valid = 1'b0;
        check_val("done_seen", got, 1'b1);
        check_val("latency", edges, BW + stalls);
        check_val("busy_at_done", busy, 1'b0);
        check_val("product", product, m_prod);
        check_val("acc24", acc, m_acc24);
        check_val("ovf24", overflow, m_ovf24);
        check_val("done16", done16, 1'b1);
        check_val("product16", product16, m_prod);
        check_val("acc16", acc16, m_acc16);
        check_val("ovf16", overflow16, m_ovf16);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW-1:0] rb;
        rst = 1'b1; start = 1'b0; clear_acc = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        multiplicand = '0;
        m_acc24 = 0; m_acc16 = 0; m_ovf24 = 1'b0; m_ovf16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_product", product, 0);
        check_val("rst_acc", acc, 0);
        check_val("rst_ovf", overflow, 1'b0);
        rst = 1'b0;

`ifdef BITSERIAL_MAC_SIGNED_EN
        run_op(8'hFD, 8'h05, 1'b1, 0, 1'b0);
        check_val("tp_neg3x5_prod", product, 16'hFFF1);
        check_val("tp_neg3x5_acc", acc, 24'hFFFFF1);
        run_op(8'h7F, 8'h80, 1'b0, 0, 1'b0);
        check_val("tp_127xneg128_acc", acc, 24'hFFC071);
        check_val("tp_127xneg128_ovf", overflow, 1'b0);
`else
        run_op(8'd2, 8'd6, 1'b1, 0, 1'b0);
        check_val("tp_2x6_prod", product, 16'h000C);
        check_val("tp_2x6_acc", acc, 24'h00000C);
        @(negedge clk);
        check_val("done_pulse_width", done, 1'b0);
        check_val("idle_busy", busy, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
        check_val("tp_acc16_wrap", acc16, 16'hFC02);
        check_val("tp_ovf16_set", overflow16, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
        check_val("tp_ff_prod", product, 16'hFE01);
        check_val("tp_ff_acc", acc, 24'h02FA03);
        check_val("tp_ff_ovf", overflow, 1'b0);
        run_op(8'd1, 8'd1, 1'b1, 0, 1'b0);
        check_val("tp_clear_acc16", acc16, 16'h0001);
        check_val("tp_clear_ovf16", overflow16, 1'b0);
        run_op(8'hA5, 8'h3C, 1'b0, 40, 1'b1);
        check_val("tp_a5x3c_prod", product, 16'h26AC);
`endif

        // abort mid-product, with start asserted alongside rst
        rb = BW'($urandom);
        start = 1'b1; multiplicand = AW'($urandom); bit_in = rb[0]; clear_acc = 1'b0;
        @(posedge clk);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; bit_valid = 1'b1; bit_in = rb[i];
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b1; bit_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_done", done, 1'b0);
        check_val("abort_product", product, 0);
        check_val("abort_acc", acc, 0);
        check_val("abort_ovf", overflow, 1'b0);
        check_val("abort_acc16", acc16, 0);
        rst = 1'b0; start = 1'b0;
        m_acc24 = 0; m_acc16 = 0; m_ovf24 = 1'b0; m_ovf16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_no_done", done, 1'b0);
        end
        run_op(8'd3, 8'd3, 1'b0, 0, 1'b0);
        check_val("tp_3x3_prod", product, 16'h0009);

        for (int n = 0; n < 16; n++) begin
            run_op(AW'($urandom), BW'($urandom), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 50)), 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
